// File: rtl/fu_alu_pkg.sv
// Shared opcode enumeration, legal parameter ranges and the multiplier build switch.
// Build option: define FU_ALU_MUL_EN to include the multiplier (MUL and MAC opcodes).
package fu_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_MUL   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_XOR   = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_PASS0 = 4'd8,
        OP_PASS1 = 4'd9,
        OP_ASHR  = 4'd10,
        OP_SLT   = 4'd11,
        OP_EQ    = 4'd12,
        OP_ACC   = 4'd13,
        OP_MAC   = 4'd14,
        OP_NOP   = 4'd15
    } op_e;

    localparam int SIZE_MIN  = 8;
    localparam int SIZE_MAX  = 64;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 4;

`ifdef FU_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    // Without the multiplier, MAC degrades to a plain single-beat NOP.
    function automatic logic is_acc_op(input op_e op);
        return (op == OP_ACC) || (MUL_EN && (op == OP_MAC));
    endfunction

endpackage

// File: rtl/fu_alu_core.sv
// Combinational per-beat ALU; for ACC/MAC it produces the term to be accumulated.
// Build option: FU_ALU_MUL_EN adds the multiplier for MUL and MAC.
module fu_alu_core
    import fu_alu_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  op_e             op,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] res
);

    localparam logic [SIZE-1:0] SIZE_V = SIZE'(SIZE);

    logic shift_ovf;
    assign shift_ovf = (b >= SIZE_V);

    always_comb begin
        res = '0;
        case (op)
            OP_ADD:   res = a + b;
            OP_SUB:   res = a - b;
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            // Shift amount is the full unsigned in1; oversize amounts saturate.
            OP_SHL:   res = shift_ovf ? '0 : (a << b);
            OP_SHR:   res = shift_ovf ? '0 : (a >> b);
            OP_ASHR:  res = shift_ovf ? {SIZE{a[SIZE-1]}} : SIZE'($signed(a) >>> b);
            OP_PASS0: res = a;
            OP_PASS1: res = b;
            OP_SLT:   res = {{(SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_EQ:    res = {{(SIZE-1){1'b0}}, (a == b)};
            OP_ACC:   res = a;
`ifdef FU_ALU_MUL_EN
            OP_MUL:   res = a * b;
            OP_MAC:   res = a * b;
`endif
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/fu_alu_acc_2_1.sv
// Pipelined ALU with ACC/MAC run accumulation and a DEPTH-cycle output delay line.
// Build option: FU_ALU_MUL_EN enables the multiplier (opcodes MUL and MAC).
module fu_alu_acc_2_1
    import fu_alu_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int DEPTH = 2,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       config_sig,
    input  logic [ACC_W-1:0] acc_len,
    input  logic [SIZE-1:0]  in0,
    input  logic [SIZE-1:0]  in1,
    input  logic             in_valid,
    output logic [SIZE-1:0]  out0,
    output logic             out_valid
);

    if (SIZE < SIZE_MIN || SIZE > SIZE_MAX) begin : g_bad_size
        $error("fu_alu_acc_2_1: SIZE out of range");
    end
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("fu_alu_acc_2_1: DEPTH out of range");
    end

    op_e             op;
    logic [SIZE-1:0] beat_res;

    assign op = op_e'(config_sig);

    fu_alu_core #(.SIZE(SIZE)) u_core (
        .op  (op),
        .a   (in0),
        .b   (in1),
        .res (beat_res)
    );

    logic [SIZE-1:0]  acc_q;
    logic [ACC_W-1:0] cnt_q;
    logic [ACC_W-1:0] len_q;
    op_e              prev_op_q;
    logic [DEPTH-1:0] v_pipe;
    logic [SIZE-1:0]  d_pipe [DEPTH];

    logic             acc_beat;
    logic             run_same;
    logic             last_beat;
    logic             emit;
    logic [SIZE-1:0]  acc_base;
    logic [SIZE-1:0]  acc_sum;
    logic [SIZE-1:0]  emit_data;
    logic [ACC_W-1:0] cnt_base;
    logic [ACC_W-1:0] cnt_next;
    logic [ACC_W-1:0] len_eff;

    // An opcode change drops the partial run before this beat is folded in.
    always_comb begin
        acc_beat  = is_acc_op(op);
        run_same  = (op == prev_op_q);
        acc_base  = run_same ? acc_q : '0;
        cnt_base  = run_same ? cnt_q : '0;
        len_eff   = (cnt_base != '0) ? len_q :
                    (acc_len == '0)  ? ACC_W'(1) : acc_len;
        cnt_next  = cnt_base + ACC_W'(1);
        acc_sum   = acc_base + beat_res;
        last_beat = (cnt_next == len_eff);
        emit      = in_valid && (!acc_beat || last_beat);
        emit_data = acc_beat ? acc_sum : beat_res;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            prev_op_q <= OP_ADD;
            v_pipe    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_pipe[i] <= '0;
            end
        end else begin
            if (in_valid) begin
                prev_op_q <= op;
                if (acc_beat && !last_beat) begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_next;
                    len_q <= len_eff;
                end else begin
                    acc_q <= '0;
                    cnt_q <= '0;
                end
            end
            // Data stages load only with their valid so out0 holds between results.
            v_pipe[0] <= emit;
            if (emit) begin
                d_pipe[0] <= emit_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                if (v_pipe[i-1]) begin
                    d_pipe[i] <= d_pipe[i-1];
                end
            end
        end
    end

    assign out_valid = v_pipe[DEPTH-1];
    assign out0      = d_pipe[DEPTH-1];

endmodule

// File: tb/tb_fu_alu_acc_2_1.sv
// Directed bench for fu_alu_acc_2_1: expected results are queued at drive time and checked at output.
module tb_fu_alu_acc_2_1;

    localparam int SIZE  = 32;
    localparam int DEPTH = 2;
    localparam int ACC_W = 8;

`ifdef FU_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       config_sig = 4'd0;
    logic [ACC_W-1:0] acc_len = '0;
    logic [SIZE-1:0]  in0 = '0;
    logic [SIZE-1:0]  in1 = '0;
    logic             in_valid = 1'b0;
    logic [SIZE-1:0]  out0;
    logic             out_valid;

    always #5 clk = ~clk;

    fu_alu_acc_2_1 #(.SIZE(SIZE), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .config_sig (config_sig),
        .acc_len    (acc_len),
        .in0        (in0),
        .in1        (in1),
        .in_valid   (in_valid),
        .out0       (out0),
        .out_valid  (out_valid)
    );

    typedef struct {
        logic [SIZE-1:0] data;
        int              due;
        string           tag;
    } exp_t;

    exp_t            sb[$];
    exp_t            mon_e;
    int              n_assert = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    logic            rst_q    = 1'b1;
    logic [SIZE-1:0] hold_exp = '0;

    logic [SIZE-1:0] m_acc  = '0;
    int              m_cnt  = 0;
    int              m_len  = 1;
    logic [3:0]      m_prev = 4'd0;

    always @(posedge clk) begin
        cyc++;
        rst_q = reset;
    end

    function automatic logic [SIZE-1:0] ref_alu(input logic [3:0] op, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        logic [SIZE-1:0] r;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = MUL_EN ? a * b : '0;
            4'd3:  r = a & b;
            4'd4:  r = a | b;
            4'd5:  r = a ^ b;
            4'd6:  r = (b >= SIZE) ? '0 : a << b[4:0];
            4'd7:  r = (b >= SIZE) ? '0 : a >> b[4:0];
            4'd8:  r = a;
            4'd9:  r = b;
            4'd10: r = (b >= SIZE) ? {SIZE{a[SIZE-1]}} : SIZE'($signed(a) >>> b[4:0]);
            4'd11: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12: r = (a == b) ? 32'd1 : 32'd0;
            4'd13: r = a;
            4'd14: r = MUL_EN ? a * b : '0;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic push_exp(input logic [SIZE-1:0] d, input string tag);
        exp_t e;
        e.data = d;
        e.due  = cyc + DEPTH;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic beat(input logic [3:0] op, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input int len, input string tag);
        logic [SIZE-1:0] t;
        bit              is_acc;
        @(negedge clk);
        reset      = 1'b0;
        in_valid   = 1'b1;
        config_sig = op;
        in0        = a;
        in1        = b;
        acc_len    = len[ACC_W-1:0];
        t      = ref_alu(op, a, b);
        is_acc = (op == 4'd13) || (MUL_EN && op == 4'd14);
        if (is_acc) begin
            if (op != m_prev) begin
                m_acc = '0;
                m_cnt = 0;
            end
            if (m_cnt == 0) m_len = (len == 0) ? 1 : len;
            m_acc = m_acc + t;
            m_cnt++;
            if (m_cnt == m_len) begin
                push_exp(m_acc, tag);
                m_acc = '0;
                m_cnt = 0;
            end
        end else begin
            push_exp(t, tag);
            m_acc = '0;
            m_cnt = 0;
        end
        m_prev = op;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            reset      = 1'b0;
            in_valid   = 1'b0;
            config_sig = 4'($urandom);
            in0        = $urandom;
            in1        = $urandom;
            acc_len    = ACC_W'($urandom);
        end
    endtask

    // Reset may coincide with a valid beat; that beat must be ignored.
    task automatic apply_reset(input int n, input bit with_valid);
        repeat (n) begin
            @(negedge clk);
            reset      = 1'b1;
            in_valid   = with_valid;
            config_sig = 4'd13;
            in0        = 32'd100;
        end
        m_acc  = '0;
        m_cnt  = 0;
        m_prev = 4'd0;
        sb.delete();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        idle(1);
        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL drain: observed pending=%0d expected pending=0", sb.size());
        end
    endtask

    always @(negedge clk) begin
        if (rst_q) begin
            n_assert++;
            assert (out_valid === 1'b0 && out0 === '0) else begin
                n_fail++;
                $error("FAIL reset_state: observed valid=%b out0=%h expected valid=0 out0=0", out_valid, out0);
            end
            hold_exp = '0;
        end else if (out_valid === 1'b1) begin
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_valid: observed out0=%h expected no output", out0);
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                n_assert++;
                assert (out0 === mon_e.data) else begin
                    n_fail++;
                    $error("FAIL %s data: observed=%h expected=%h", mon_e.tag, out0, mon_e.data);
                end
                n_assert++;
                assert (cyc == mon_e.due) else begin
                    n_fail++;
                    $error("FAIL %s latency: observed cycle=%0d expected cycle=%0d", mon_e.tag, cyc, mon_e.due);
                end
                hold_exp = mon_e.data;
            end
        end else begin
            n_assert++;
            assert (out0 === hold_exp) else begin
                n_fail++;
                $error("FAIL hold: observed out0=%h expected=%h", out0, hold_exp);
            end
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                mon_e = sb.pop_front();
                n_assert++;
                n_fail++;
                $error("FAIL %s missing: observed no out_valid expected out0=%h at cycle %0d", mon_e.tag, mon_e.data, mon_e.due);
            end
        end
    end

    initial begin
        logic [3:0]      rop;
        logic [SIZE-1:0] ra;
        logic [SIZE-1:0] rb;
        logic [3:0]      op_list [14];
        op_list = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd15};

        apply_reset(2, 1'b0);
        idle(1);
        n_assert++;
        assert (out_valid === 1'b0) else begin
            n_fail++;
            $error("FAIL post_reset_valid: observed=%b expected=0", out_valid);
        end
        n_assert++;
        assert (out0 === '0) else begin
            n_fail++;
            $error("FAIL post_reset_out0: observed=%h expected=0", out0);
        end

        beat(4'd0, 32'd5, 32'd7, 1, "add_5_7");
        idle(4);

        beat(4'd10, 32'h8000_0000, 32'd40, 1, "ashr_40");
        beat(4'd6,  32'h0000_0001, 32'd32, 1, "shl_32");
        beat(4'd7,  32'h0000_00F0, 32'd4,  1, "shr_4");
        beat(4'd10, 32'h8000_0000, 32'd31, 1, "ashr_31");
        beat(4'd11, 32'hFFFF_FFFF, 32'd1,  1, "slt_neg");
        beat(4'd12, 32'd9,         32'd9,  1, "eq");
        beat(4'd1,  32'd3,         32'd5,  1, "sub_wrap");
        idle(3);

        for (int i = 0; i < 24; i++) begin
            rop = op_list[$urandom_range(0, 13)];
            ra  = $urandom;
            rb  = (rop == 4'd6 || rop == 4'd7 || rop == 4'd10) ? SIZE'($urandom_range(0, 40)) : $urandom;
            beat(rop, ra, rb, 1, "sweep");
        end
        idle(4);

        beat(4'd13, 32'd1, 32'd0, 4, "acc4");
        beat(4'd13, 32'd2, 32'd0, 7, "acc4");
        beat(4'd13, 32'd3, 32'd0, 7, "acc4");
        beat(4'd13, 32'd4, 32'd0, 0, "acc4");
        idle(4);

        beat(4'd14, 32'd2,  32'd3,  3, "mac_partial");
        beat(4'd14, 32'd4,  32'd5,  3, "mac_partial");
        beat(4'd0,  32'd10, 32'd20, 3, "add_after_mac");
        idle(4);

        beat(4'd13, 32'd9, 32'd0, 0, "acc_len0");
        idle(3);

        beat(4'd13, 32'd5, 32'd0, 3, "acc_to_mac");
        beat(4'd13, 32'd6, 32'd0, 3, "acc_to_mac");
        beat(4'd14, 32'd2, 32'd3, 2, "acc_to_mac");
        beat(4'd14, 32'd4, 32'd4, 2, "acc_to_mac");
        idle(4);

        drain();
        beat(4'd13, 32'd1, 32'd0, 4, "acc_pre_reset");
        beat(4'd13, 32'd2, 32'd0, 4, "acc_pre_reset");
        apply_reset(1, 1'b1);
        beat(4'd13, 32'd10, 32'd0, 4, "acc_after_reset");
        beat(4'd13, 32'd20, 32'd0, 4, "acc_after_reset");
        beat(4'd13, 32'd30, 32'd0, 4, "acc_after_reset");
        beat(4'd13, 32'd40, 32'd0, 4, "acc_after_reset");
        idle(4);

        beat(4'd2, 32'd3, 32'd4, 1, "mul_3_4");
        idle(3);

        for (int i = 0; i < 255; i++) begin
            beat(4'd13, 32'd1, 32'd0, (i == 0) ? 255 : 3, "acc255");
        end
        idle(1);

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
